// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered inputs, 11-bit frame capture,
// E0/F0 prefix folding and a first-word-fall-through event FIFO.
`timescale 1ns/1ps
module ps2_kbd_rx #(
    parameter int FIFO_AW        = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rd_en,
    output logic               evt_valid,
    output logic [7:0]         evt_code,
    output logic               evt_break,
    output logic               evt_ext,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Input synchronisers: bit 0 is the clock line, bit 1 the data line.
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
        end else begin
            sync1_reg <= {ps2_data, ps2_clk};
            sync2_reg <= sync1_reg;
        end
    end

    assign clk_s  = sync2_reg[0];
    assign data_s = sync2_reg[1];

    // Glitch filter: the filtered clock follows only a run of FILTER_LEN differing samples.
    logic       filt_clk_reg;
    logic [3:0] filt_cnt_reg;
    logic       strobe_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
            strobe_reg   <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;
            if (clk_s == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == 4'(FILTER_LEN - 1)) begin
                filt_clk_reg <= clk_s;
                filt_cnt_reg <= '0;
                strobe_reg   <= filt_clk_reg;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 4'd1;
            end
        end
    end

    // Frame engine
    state_t           state_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt_reg;
    logic             par_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             acc_valid_reg;
    logic [7:0]       acc_byte_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            par_reg       <= 1'b0;
            tmo_cnt_reg   <= '0;
            acc_valid_reg <= 1'b0;
            acc_byte_reg  <= '0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            acc_valid_reg <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            if (strobe_reg) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (!data_s) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {data_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_reg   <= data_s;
                        state_reg <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        // A bad parity bit takes precedence over a bad stop bit.
                        if (!(^{shift_reg, par_reg})) begin
                            parity_err <= 1'b1;
                        end else if (!data_s) begin
                            frame_err <= 1'b1;
                        end else begin
                            acc_valid_reg <= 1'b1;
                            acc_byte_reg  <= shift_reg;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE) begin
                if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_reg   <= IDLE;
                    frame_err   <= 1'b1;
                    tmo_cnt_reg <= '0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end

    // Prefix decoder
    logic       ext_reg;
    logic       brk_reg;
    logic       is_prefix;
    logic       push;
    logic [9:0] push_data;

    assign is_prefix = (acc_byte_reg == 8'hE0) || (acc_byte_reg == 8'hF0);
    assign push      = acc_valid_reg && !is_prefix;
    assign push_data = {ext_reg, brk_reg, acc_byte_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (parity_err || frame_err) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (acc_valid_reg) begin
            if (acc_byte_reg == 8'hE0) begin
                ext_reg <= 1'b1;
            end else if (acc_byte_reg == 8'hF0) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Event FIFO
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               full;
    logic               do_pop;
    logic               do_push;
    logic [9:0]         head;

    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = rd_en && (count_reg != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head       = mem[rd_ptr_reg];
    assign evt_valid  = (count_reg != '0);
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_break  = evt_valid ? head[8] : 1'b0;
    assign evt_ext    = evt_valid ? head[9] : 1'b0;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames and checks events, error pulses and FIFO state.
// The PS/2 bit period and the timeout are scaled down together to keep the run short.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FIFO_AW = 3;
    localparam int TMO     = 300;
    localparam int Q       = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic             rd_en = 1'b0;
    logic             evt_valid;
    logic [7:0]       evt_code;
    logic             evt_break;
    logic             evt_ext;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;
    logic             parity_err;
    logic             frame_err;

    int n_pass  = 0;
    int n_total = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int base_p;
    int base_f;
    bit got_push;

    ps2_kbd_rx #(
        .FIFO_AW(FIFO_AW),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rd_en(rd_en),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .evt_break(evt_break),
        .evt_ext(evt_ext),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .parity_err(parity_err),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (parity_err) n_perr <= n_perr + 1;
        if (frame_err)  n_ferr <= n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Bits leave LSB first; data changes in the middle of the high phase.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_clk = 1'b1;
            #Q;
            ps2_data = bits[i];
            #Q;
            ps2_clk = 1'b0;
            #(2 * Q);
        end
        ps2_clk = 1'b1;
        #Q;
        ps2_data = 1'b1;
        #Q;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bits(mk(d, 1'b0), 11);
        #(4 * Q);
    endtask

    task automatic pop;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] code, input logic brk,
                              input logic ext, input int cnt);
        @(negedge clk);
        check({tag, "_code"}, 32'(evt_code), 32'(code));
        check({tag, "_brk"},  32'(evt_break), 32'(brk));
        check({tag, "_ext"},  32'(evt_ext), 32'(ext));
        check({tag, "_cnt"},  32'(fifo_count), 32'(cnt));
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_code", 32'(evt_code), 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain make code
        base_p = n_perr;
        base_f = n_ferr;
        send_frame(8'h1C);
        @(negedge clk);
        check("make_valid", 32'(evt_valid), 32'd1);
        check_head("make", 8'h1C, 1'b0, 1'b0, 1);
        check("make_perr", 32'(n_perr - base_p), 32'd0);
        check("make_ferr", 32'(n_ferr - base_f), 32'd0);
        pop();
        @(negedge clk);
        check("make_pop_valid", 32'(evt_valid), 32'd0);
        check("make_pop_code", 32'(evt_code), 32'd0);

        // Break, then extended break
        send_frame(8'hF0);
        send_frame(8'h1C);
        check_head("brk", 8'h1C, 1'b1, 1'b0, 1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h74);
        check_head("extbrk_first", 8'h1C, 1'b1, 1'b0, 2);
        pop();
        check_head("extbrk_second", 8'h74, 1'b1, 1'b1, 1);
        pop();
        check_head("extbrk_empty", 8'h00, 1'b0, 1'b0, 0);

        // Parity error drops the byte and clears the pending break prefix
        base_p = n_perr;
        base_f = n_ferr;
        send_frame(8'hF0);
        send_bits(mk(8'h1C, 1'b1), 11);
        #(4 * Q);
        check("par_pulse", 32'(n_perr - base_p), 32'd1);
        check("par_noferr", 32'(n_ferr - base_f), 32'd0);
        check("par_cnt", 32'(fifo_count), 32'd0);
        send_frame(8'h1C);
        check_head("par_after", 8'h1C, 1'b0, 1'b0, 1);
        pop();

        // Timeout on a partial frame
        base_f = n_ferr;
        send_bits(mk(8'h1C, 1'b0), 5);
        repeat (2 * TMO) @(negedge clk);
        check("tmo_pulse", 32'(n_ferr - base_f), 32'd1);
        check("tmo_cnt", 32'(fifo_count), 32'd0);
        send_frame(8'h29);
        check_head("tmo_after", 8'h29, 1'b0, 1'b0, 1);
        pop();

        // Short low glitch on the clock line is filtered out
        base_p = n_perr;
        base_f = n_ferr;
        @(negedge clk);
        ps2_clk = 1'b0;
        #20;
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_ferr", 32'(n_ferr - base_f), 32'd0);
        send_frame(8'h1C);
        check_head("glitch_after", 8'h1C, 1'b0, 1'b0, 1);
        check("glitch_perr", 32'(n_perr - base_p), 32'd0);
        pop();

        // Overflow: nine codes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i));
        end
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        check_head("ovf_head", 8'h01, 1'b0, 1'b0, 8);

        // Pop on the push cycle while full: both happen
        got_push = 1'b0;
        fork
            send_frame(8'h0A);
            begin
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (dut.push) begin
                        rd_en = 1'b1;
                        @(negedge clk);
                        rd_en = 1'b0;
                        got_push = 1'b1;
                        break;
                    end
                end
            end
        join
        check("pushpop_seen", 32'(got_push), 32'd1);
        check_head("pushpop", 8'h02, 1'b0, 1'b0, 8);
        for (int i = 2; i <= 8; i++) begin
            pop();
        end
        check_head("pushpop_tail", 8'h0A, 1'b0, 1'b0, 1);

        // Reset in the middle of a frame
        send_bits(mk(8'h5A, 1'b0), 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_valid", 32'(evt_valid), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check_head("mrst", 8'h00, 1'b0, 1'b0, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1C);
        check_head("mrst_after", 8'h1C, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
